// File: rtl/nsa_pkg.sv
// Shared definitions for the nibble-serial adder: FSM state encoding,
// nibble width and the counter-width helper.
package nsa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLE = 4;

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/full_adder_4.sv
// 4-bit ripple-carry adder used as the shared nibble datapath.
module full_adder_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder that pushes one nibble per clock through a
// single full_adder_4, LSB nibble first, and pulses done with the result.
// Optional feature macro: NSA_SUB_EN adds the sub port (a - b on request).
//
// Handshake: start is sampled on each rising edge and accepted only in IDLE
// or DONE; busy is high during RUN, done is a one-cycle pulse during which
// sum/cout are valid, and they hold until the next accepted start.
// WIDTH must be a multiple of 4 and at least 4.
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef NSA_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int N  = WIDTH / NIBBLE;
  localparam int CW = cnt_width(N);

  state_t state, next_state;

  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             cout_q;

  logic             accept;
  logic             last;
  logic [3:0]       nib_s;
  logic             nib_c;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;
  logic [WIDTH-1:0] s_top;

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign last   = (cnt_q == CW'(N - 1));

`ifdef NSA_SUB_EN
  // Subtraction is a + ~b + 1; cin is ignored for a subtract.
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub ? 1'b1 : cin;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif

  // Fresh nibble sum placed in the top nibble of the result register.
  assign s_top = WIDTH'(nib_s) << (WIDTH - NIBBLE);

  full_adder_4 u_nibble (
    .a    (a_q[3:0]),
    .b    (b_q[3:0]),
    .cin  (carry_q),
    .s    (nib_s),
    .cout (nib_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (last)  next_state = DONE;
      DONE:    next_state = start ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Status outputs decoded from state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Operand shift registers, nibble counter, carry and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b_load;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= carry_load;
      cout_q  <= 1'b0;
    end else if (state == RUN) begin
      a_q     <= a_q >> NIBBLE;
      b_q     <= b_q >> NIBBLE;
      sum_q   <= (sum_q >> NIBBLE) | s_top;
      cnt_q   <= cnt_q + CW'(1);
      carry_q <= nib_c;
      if (last) cout_q <= nib_c;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed, table-driven bench for nibble_serial_adder (WIDTH=16).
module tb_nibble_serial_adder;

  localparam int W = 16;
  localparam int N = W / 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         sub;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  vec_t vecs[$];

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef NSA_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count edges until done is seen (bounded); returns 0 on timeout.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      if (busy) busy_cnt++;
      tick();
      if (done) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: done not seen within 20 cycles");
    end
  endtask

  // Issue one operation (called just after an edge) and check the result.
  task automatic do_op(input vec_t v, input string tag);
    int lat, bc;
    start = 1'b1; a = v.a; b = v.b; cin = v.cin; sub = v.sub;
    tick();
    start = 1'b0; a = $urandom_range(0, 65535); b = $urandom_range(0, 65535);
    cin = 1'b0; sub = 1'b0;
    check({tag, " busy_after_start"}, busy, 1);
    check({tag, " done_after_start"}, done, 0);
    wait_done(lat, bc);
    check({tag, " latency"}, lat, N);
    check({tag, " busy_cycles"}, bc, N);
    check({tag, " sum"}, sum, v.exp_sum);
    check({tag, " cout"}, cout, v.exp_cout);
    check({tag, " busy_in_done"}, busy, 0);
  endtask

  initial begin
    int lat, bc;
    vec_t v;

    // Stimulus table.
    vecs.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0});
    vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0});
    vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1});
    vecs.push_back('{16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0});
    vecs.push_back('{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0});
`ifdef NSA_SUB_EN
    vecs.push_back('{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0});
    vecs.push_back('{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1});
`endif

    // Reset.
    reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset sum", sum, 0);
    check("reset cout", cout, 0);
    tick();

    // Table: each op from IDLE, then one idle cycle checking hold and pulse.
    for (int i = 0; i < vecs.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      do_op(vecs[i], tag);
      tick();
      check({tag, " done_pulse"}, done, 0);
      check({tag, " sum_hold"}, sum, vecs[i].exp_sum);
      check({tag, " cout_hold"}, cout, vecs[i].exp_cout);
    end

    // Start during RUN is ignored; start held in DONE is accepted.
    start = 1'b1; a = 16'h0001; b = 16'h0001; cin = 1'b0;
    tick();                                   // T0
    start = 1'b0;
    tick();                                   // T1
    start = 1'b1; a = 16'hAAAA; b = 16'h5555; // sampled at T2
    tick();                                   // T2
    start = 1'b0;
    check("midrun busy", busy, 1);
    wait_done(lat, bc);
    check("midrun latency", lat, N - 2);
    check("midrun sum", sum, 16'h0002);
    check("midrun cout", cout, 0);
    start = 1'b1; a = 16'hAAAA; b = 16'h5555; cin = 1'b0;
    tick();                                   // accepted in DONE
    start = 1'b0;
    check("b2b done_drop", done, 0);
    check("b2b busy_rise", busy, 1);
    wait_done(lat, bc);
    check("b2b period", lat + 1, N + 1);
    check("b2b sum", sum, 16'hFFFF);
    check("b2b cout", cout, 0);
    tick();

    // Reset mid-RUN aborts; a new start then works normally.
    start = 1'b1; a = 16'h1111; b = 16'h1111;
    tick();                                   // T0
    start = 1'b0;
    tick();                                   // T1
    reset = 1'b1;
    tick();                                   // T2
    reset = 1'b0;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort sum", sum, 0);
    check("abort cout", cout, 0);
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 8; k++) begin
        tick();
        if (done || busy) seen = 1;
      end
      check("abort quiet", seen, 0);
    end
    v = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0};
    do_op(v, "after_abort");

    // Reset has priority over start on the same edge.
    tick();
    start = 1'b1; reset = 1'b1; a = 16'h0001; b = 16'h0001;
    tick();
    start = 1'b0; reset = 1'b0;
    check("rst_prio busy", busy, 0);
    check("rst_prio sum", sum, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
